// File: rtl/axis_read_data.sv
// axis_read_data: read-side data path of the AXI stream bridge.
// Accepts AXI read beats into a circular buffer and unpacks each wide word
// into 2^CONVERT_SHIFT narrow stream words, lowest lane first.
module axis_read_data #(
  parameter int BUF_AWIDTH     = 4,
  parameter int CFG_DWIDTH     = 32,
  parameter int CONVERT_SHIFT  = 1,
  parameter int AXI_LEN_WIDTH  = 4,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int DATA_WIDTH     = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CFG_DWIDTH-1:0]     cfg_length,
  input  logic                      cfg_val,
  output logic                      cfg_rdy,
  input  logic [AXI_DATA_WIDTH-1:0] axi_rdata,
  input  logic                      axi_rlast,
  input  logic                      axi_rvalid,
  output logic                      axi_rready,
  output logic [DATA_WIDTH-1:0]     data,
  output logic                      valid,
  input  logic                      ready
);

  localparam int RATIO  = 1 << CONVERT_SHIFT;
  localparam int LANE_W = (CONVERT_SHIFT > 0) ? CONVERT_SHIFT : 1;
  localparam int DEPTH  = 1 << BUF_AWIDTH;
  localparam logic [CFG_DWIDTH-1:0] CfgOne     = 1;
  localparam logic [CFG_DWIDTH-1:0] RatioMinus = CFG_DWIDTH'(RATIO - 1);
  localparam logic [BUF_AWIDTH:0]   PtrOne     = 1;
  localparam logic [LANE_W-1:0]     LaneOne    = 1;
  localparam logic [LANE_W-1:0]     LaneLast   = LANE_W'(RATIO - 1);

  // Burst length and rlast play no part in counting; beats are counted directly.
  localparam int unused_len_w = AXI_LEN_WIDTH;
  logic unused_rlast;
  assign unused_rlast = axi_rlast;

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t                  state_q, state_d;
  logic                    out_of_reset_q;
  logic [CFG_DWIDTH-1:0]   beats_left_q, words_left_q;
  logic [LANE_W-1:0]       lane_q;
  logic [BUF_AWIDTH:0]     wr_ptr_q, rd_ptr_q;
  logic [AXI_DATA_WIDTH-1:0] mem [DEPTH];

  logic buf_empty, buf_full;
  logic cfg_fire, push, hs, last_hs, pop;
  logic [AXI_DATA_WIDTH-1:0] head_word;
  logic [DATA_WIDTH-1:0]     lanes [RATIO];

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign buf_empty = (wr_ptr_q == rd_ptr_q);
  assign buf_full  = (wr_ptr_q[BUF_AWIDTH] != rd_ptr_q[BUF_AWIDTH]) &&
                     (wr_ptr_q[BUF_AWIDTH-1:0] == rd_ptr_q[BUF_AWIDTH-1:0]);

  assign cfg_fire = cfg_val & cfg_rdy;
  assign push     = axi_rvalid & axi_rready;
  assign hs       = valid & ready;
  assign last_hs  = hs & (words_left_q == CfgOne);
  // Final word pops the head even if upper lanes of that beat are unused.
  assign pop      = hs & ((lane_q == LaneLast) | (words_left_q == CfgOne));

  assign head_word = mem[rd_ptr_q[BUF_AWIDTH-1:0]];

  for (genvar gi = 0; gi < RATIO; gi++) begin : g_lane
    assign lanes[gi] = head_word[gi*DATA_WIDTH +: DATA_WIDTH];
  end

  // State register; out_of_reset_q holds cfg_rdy low through reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      out_of_reset_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      out_of_reset_q <= 1'b1;
    end
  end

  // Next state: zero-length configs are absorbed without leaving IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cfg_fire && (cfg_length != '0)) state_d = ACTIVE;
      ACTIVE:  if (last_hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs: request beats only while some remain and there is room.
  always_comb begin
    cfg_rdy    = (state_q == IDLE) & out_of_reset_q;
    axi_rready = (state_q == ACTIVE) & (beats_left_q != '0) & ~buf_full;
    valid      = (state_q == ACTIVE) & ~buf_empty;
    data       = valid ? lanes[lane_q] : '0;
  end

  // Beat/word counters, lane index and buffer pointers.
  always_ff @(posedge clk) begin
    if (rst) begin
      beats_left_q <= '0;
      words_left_q <= '0;
      lane_q       <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
    end else begin
      if (cfg_fire) begin
        beats_left_q <= (cfg_length + RatioMinus) >> CONVERT_SHIFT;
        words_left_q <= cfg_length;
        lane_q       <= '0;
      end else begin
        if (push) beats_left_q <= beats_left_q - CfgOne;
        if (hs) begin
          words_left_q <= words_left_q - CfgOne;
          lane_q       <= pop ? '0 : lane_q + LaneOne;
        end
      end
      if (push) wr_ptr_q <= wr_ptr_q + PtrOne;
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrOne;
    end
  end

  // Beat storage; no reset so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q[BUF_AWIDTH-1:0]] <= axi_rdata;
  end

endmodule

// File: tb/tb_axis_read_data.sv
// Directed bench for axis_read_data: beat k carries stream words 2k+1 (lane 0)
// and 2k+2 (lane 1), so every transfer must emit 1..L in order.
module tb_axis_read_data;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] cfg_length;
  logic        cfg_val;
  logic        cfg_rdy;
  logic [63:0] axi_rdata;
  logic        axi_rlast;
  logic        axi_rvalid;
  logic        axi_rready;
  logic [31:0] data;
  logic        valid;
  logic        ready;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  axis_read_data dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_length (cfg_length),
    .cfg_val    (cfg_val),
    .cfg_rdy    (cfg_rdy),
    .axi_rdata  (axi_rdata),
    .axi_rlast  (axi_rlast),
    .axi_rvalid (axi_rvalid),
    .axi_rready (axi_rready),
    .data       (data),
    .valid      (valid),
    .ready      (ready)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present beat number k of the source.
  task automatic drive_beat(input int k);
    axi_rdata = {32'(2 * k + 2), 32'(2 * k + 1)};
    axi_rlast = (k % 4) == 3;
  endtask

  // One complete transfer. Called and returns at posedge+1.
  // rdy_mode: 0 = ready always, 1 = alternating, 2 = held low for 30 cycles.
  task automatic run_xfer(input string name, input int len, input int rv_period,
                          input int rdy_mode, output int cycles);
    int beats = 0;
    int words = 0;
    int waitc = 0;
    int cyc;
    logic prev_stall = 1'b0;
    logic [31:0] prev_data = '0;
    while (!cfg_rdy && waitc < 20) begin
      @(posedge clk); #1;
      waitc++;
    end
    check({name, " cfg_rdy idle"}, 64'(cfg_rdy), 64'd1);
    cfg_length = 32'(len);
    cfg_val    = 1'b1;
    @(posedge clk); #1;
    cfg_val = 1'b0;
    check({name, " cfg_rdy busy"}, 64'(cfg_rdy), 64'd0);
    for (cyc = 0; cyc < 20000 && words < len; cyc++) begin
      axi_rvalid = (cyc % rv_period) == 0;
      drive_beat(beats);
      if (rdy_mode == 0)      ready = 1'b1;
      else if (rdy_mode == 1) ready = (cyc % 2) == 1;
      else                    ready = (cyc >= 30);
      @(negedge clk);
      if (rdy_mode == 2 && cyc == 29) begin
        check({name, " rready when full"}, 64'(axi_rready), 64'd0);
        check({name, " beats when full"}, 64'(beats), 64'd16);
      end
      if (prev_stall) begin
        check({name, " stall valid"}, 64'(valid), 64'd1);
        check({name, " stall data"}, 64'(data), 64'(prev_data));
      end
      if (axi_rvalid && axi_rready) beats++;
      if (valid && ready) begin
        check({name, " word"}, 64'(data), 64'(words + 1));
        words++;
      end
      prev_stall = valid && !ready;
      prev_data  = data;
      @(posedge clk); #1;
    end
    axi_rvalid = 1'b0;
    @(negedge clk);
    check({name, " word count"}, 64'(words), 64'(len));
    check({name, " beat count"}, 64'(beats), 64'((len + 1) / 2));
    check({name, " valid after"}, 64'(valid), 64'd0);
    check({name, " cfg_rdy after"}, 64'(cfg_rdy), 64'd1);
    check({name, " rready after"}, 64'(axi_rready), 64'd0);
    cycles = cyc;
    $display("xfer %s: len=%0d beats=%0d words=%0d cycles=%0d", name, len, beats, words, cyc);
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cycles;
    int words;
    int beats;
    rst        = 1'b1;
    cfg_length = '0;
    cfg_val    = 1'b0;
    axi_rdata  = '0;
    axi_rlast  = 1'b0;
    axi_rvalid = 1'b0;
    ready      = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset cfg_rdy", 64'(cfg_rdy), 64'd0);
    check("reset rready", 64'(axi_rready), 64'd0);
    check("reset valid", 64'(valid), 64'd0);
    check("reset data", 64'(data), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("cfg_rdy after reset", 64'(cfg_rdy), 64'd1);

    // Full rate: one beat of latency, then one word per cycle.
    run_xfer("L8", 8, 1, 0, cycles);
    check("L8 cycles", 64'(cycles), 64'd9);
    run_xfer("L7", 7, 1, 0, cycles);
    check("L7 cycles", 64'(cycles), 64'd8);
    run_xfer("L40 full", 40, 1, 2, cycles);
    run_xfer("L8 sparse", 8, 6, 1, cycles);

    // Reset after three words of an eight-word transfer.
    cfg_length = 32'd8;
    cfg_val    = 1'b1;
    @(posedge clk); #1;
    cfg_val = 1'b0;
    words = 0;
    beats = 0;
    for (int c = 0; c < 50 && words < 3; c++) begin
      axi_rvalid = 1'b1;
      drive_beat(beats);
      ready = 1'b1;
      @(negedge clk);
      if (axi_rvalid && axi_rready) beats++;
      if (valid && ready) begin
        check("rst-run word", 64'(data), 64'(words + 1));
        words++;
      end
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst valid", 64'(valid), 64'd0);
    check("midrst rready", 64'(axi_rready), 64'd0);
    check("midrst cfg_rdy", 64'(cfg_rdy), 64'd0);
    check("midrst data", 64'(data), 64'd0);
    rst        = 1'b0;
    axi_rvalid = 1'b0;
    @(posedge clk); #1;
    check("post-rst cfg_rdy", 64'(cfg_rdy), 64'd1);
    $display("xfer reset-abort: len=8 words_before_reset=%0d", words);
    run_xfer("L8 after rst", 8, 1, 0, cycles);
    check("L8 after rst cycles", 64'(cycles), 64'd9);

    // Zero length: config is consumed but nothing happens.
    cfg_length = 32'd0;
    cfg_val    = 1'b1;
    axi_rvalid = 1'b1;
    drive_beat(0);
    ready = 1'b1;
    @(posedge clk); #1;
    cfg_val = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("L0 cfg_rdy", 64'(cfg_rdy), 64'd1);
      check("L0 rready", 64'(axi_rready), 64'd0);
      check("L0 valid", 64'(valid), 64'd0);
      @(posedge clk); #1;
    end
    axi_rvalid = 1'b0;
    $display("xfer L0: len=0 no beats requested");

    // Long transfer: pointers wrap many times.
    run_xfer("L4092", 4092, 1, 0, cycles);
    check("L4092 cycles", 64'(cycles), 64'd4093);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
